bsr_bank: RTL and testbench
===========================

Name: bsr_bank

Overview:
- Parametrised boundary-scan register bank: NUM_CH channels of CH_WIDTH cells each, chained tdi -> ch0 -> ch1 -> ... -> ch[NUM_CH-1] -> tdo.
- Sits between the core and its memories/pins, driven by the JTAG test logic's DR control strobes.
- Replaces hand-chained single-width cells with one bank that adds:
  - capture_dr support;
  - per-channel mode;
  - per-segment bypass, giving a variable chain length;
  - a shift counter and protocol-error flag for debug.

Parameters:
- NUM_CH, 6, number of channels (1..32).
- CH_WIDTH, 32, cells per channel (1..64).
- CNT_W, 16, width of shift counter.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- capture_dr  input  1  load shift regs of enabled channels from parallel_in.
- shift_dr  input  1  shift chain one bit per cycle.
- update_dr  input  1  copy shift regs of enabled channels to update regs.
- seg_en  input  NUM_CH  segment enable; sampled only on capture_dr.
- mode  input  NUM_CH  per-channel override: 1 = parallel_out driven from update reg.
- tdi  input  1  serial in.
- tdo  output  1  serial out.
- parallel_in  input  NUM_CH*CH_WIDTH  functional inputs; ch i = bits [i*CH_WIDTH +: CH_WIDTH].
- parallel_out  output  NUM_CH*CH_WIDTH  functional outputs.
- bit_count  output  CNT_W  shifts since last capture, saturating.
- proto_err  output  1  sticky: more than one strobe asserted in the same cycle.

Behaviour:
- State per channel i: sr_i[CH_WIDTH] (shift reg), upd_i[CH_WIDTH] (update reg), byp_i (1-bit bypass flop). Bank-wide state: seg_q[NUM_CH], cnt[CNT_W], err.
- Reset (async, immediate): sr=0, upd=0, byp=0, seg_q=all ones, cnt=0, err=0. Hence tdo=0, bit_count=0, proto_err=0. parallel_out = mode[i] ? 0 : parallel_in.
- Strobe priority when several are high: capture > shift > update. Only the winner acts. err<=1 whenever popcount({capture_dr,shift_dr,update_dr})>1; err clears only on reset.
- Capture:
  - seg_q<=seg_en.
  - Enabled channels (per new seg_en): sr_i<=parallel_in ch i.
  - All channels: byp_i<=0.
  - cnt<=0.
- Shift:
  - Segment input s_in_i = tdi for i=0, else s_out_{i-1}.
  - If seg_q[i]: sr_i<={s_in_i, sr_i[CH_WIDTH-1:1]}; s_out_i=sr_i[0].
  - Else: byp_i<=s_in_i; s_out_i=byp_i. sr_i is held.
  - tdo = s_out_{NUM_CH-1}, purely from flops (no combinational tdi->tdo path).
  - cnt<=cnt+1, saturating at all ones.
  - Chain length = sum over i of (seg_q[i] ? CH_WIDTH : 1).
- Update: for seg_q[i]=1, upd_i<=sr_i. Disabled channels keep upd_i.
- parallel_out ch i = mode[i] ? upd_i : parallel_in ch i. Combinational, so:
  - a new upd value is visible the cycle after update_dr is sampled;
  - a mode change takes effect in the same cycle.
- seg_en changes between captures have no effect. Segment structure is frozen for a whole scan.
- No strobe asserted: all state holds.

Test Plan (NUM_CH=3, CH_WIDTH=8, CNT_W=16):
1. Reset, mode=3'b000 -> tdo=0, bit_count=0, proto_err=0, parallel_out==parallel_in. With mode=3'b111 -> parallel_out=24'h000000.
2. parallel_in=24'hA53C0F, seg_en=3'b111, capture, 24 shifts with tdi=0 -> tdo LSB-first yields 8'hA5, then 8'h3C, then 8'h0F. bit_count=24.
3. Shift tdi bits so that sr = ch2 8'h33, ch1 8'h22, ch0 8'h11 (24 shifts), then update, mode=3'b101:
   - one cycle later parallel_out = {8'h33, parallel_in ch1, 8'h11};
   - bit_count=24.
4. seg_en=3'b010, parallel_in ch1=8'hC3, capture, 10 shifts tdi=1:
   - tdo = 0 (byp2), then 1,1,0,0,0,0,1,1 (8'hC3 LSB-first), then 0 (byp0);
   - update: upd1 changes, upd0 and upd2 unchanged.
5. capture_dr and shift_dr high in the same cycle -> capture performed, no shift, proto_err=1. proto_err remains 1 through later clean scans until reset.
6. Reset asserted asynchronously after 5 of 24 shifts -> same cycle:
   - bit_count=0, tdo=0, seg_q=3'b111, all upd=0;
   - restarting the scan of case 2 reproduces case 2 results.

Source files
------------

// File: rtl/bsr_bank_if.sv
// Boundary-scan bank bus: DR strobes, segment/mode controls, serial and parallel data.
interface bsr_bank_if #(
   parameter int unsigned NUM_CH   = 6,
   parameter int unsigned CH_WIDTH = 32,
   parameter int unsigned CNT_W    = 16
);
   logic                       capture_dr;
   logic                       shift_dr;
   logic                       update_dr;
   logic [NUM_CH-1:0]          seg_en;
   logic [NUM_CH-1:0]          mode;
   logic                       tdi;
   logic                       tdo;
   logic [NUM_CH*CH_WIDTH-1:0] parallel_in;
   logic [NUM_CH*CH_WIDTH-1:0] parallel_out;
   logic [CNT_W-1:0]           bit_count;
   logic                       proto_err;

   modport master (
      output capture_dr, shift_dr, update_dr, seg_en, mode, tdi, parallel_in,
      input  tdo, parallel_out, bit_count, proto_err
   );

   modport slave (
      input  capture_dr, shift_dr, update_dr, seg_en, mode, tdi, parallel_in,
      output tdo, parallel_out, bit_count, proto_err
   );
endinterface

// File: rtl/bsr_bank.sv
// Boundary-scan register bank: NUM_CH chained channels with per-segment bypass,
// capture/shift/update, saturating shift counter and sticky strobe-collision flag.
module bsr_bank #(
   parameter int unsigned NUM_CH   = 6,
   parameter int unsigned CH_WIDTH = 32,
   parameter int unsigned CNT_W    = 16
) (
   input  logic      clk,
   input  logic      reset,
   bsr_bank_if.slave bus
);
   localparam int unsigned TOT_W = NUM_CH * CH_WIDTH;

   logic [TOT_W-1:0]    sr_q, sr_d;
   logic [TOT_W-1:0]    upd_q, upd_d;
   logic [NUM_CH-1:0]   byp_q, byp_d;
   logic [NUM_CH-1:0]   seg_q, seg_d;
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic                err_q, err_d;
   logic [NUM_CH-1:0]   s_in, s_out;
   logic [CH_WIDTH-1:0] sh_tmp;
   logic [TOT_W-1:0]    pout_c;

   // Segment serial outputs come only from flops, so tdo never sees tdi combinationally.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++)
         s_out[i] = seg_q[i] ? sr_q[i*CH_WIDTH] : byp_q[i];
   end

   always_comb begin
      s_in[0] = bus.tdi;
      for (int unsigned i = 1; i < NUM_CH; i++)
         s_in[i] = s_out[i-1];
   end

   // Next state: capture beats shift beats update; collisions latch the error flag.
   always_comb begin
      sr_d   = sr_q;
      upd_d  = upd_q;
      byp_d  = byp_q;
      seg_d  = seg_q;
      cnt_d  = cnt_q;
      sh_tmp = '0;
      err_d  = err_q
             | (bus.capture_dr & bus.shift_dr)
             | (bus.capture_dr & bus.update_dr)
             | (bus.shift_dr   & bus.update_dr);
      if (bus.capture_dr) begin
         seg_d = bus.seg_en;
         byp_d = '0;
         cnt_d = '0;
         for (int unsigned i = 0; i < NUM_CH; i++)
            if (bus.seg_en[i])
               sr_d[i*CH_WIDTH +: CH_WIDTH] = bus.parallel_in[i*CH_WIDTH +: CH_WIDTH];
      end else if (bus.shift_dr) begin
         for (int unsigned i = 0; i < NUM_CH; i++) begin
            if (seg_q[i]) begin
               sh_tmp                       = sr_q[i*CH_WIDTH +: CH_WIDTH] >> 1;
               sh_tmp[CH_WIDTH-1]           = s_in[i];
               sr_d[i*CH_WIDTH +: CH_WIDTH] = sh_tmp;
            end else begin
               byp_d[i] = s_in[i];
            end
         end
         if (cnt_q != {CNT_W{1'b1}})
            cnt_d = cnt_q + CNT_W'(1);
      end else if (bus.update_dr) begin
         for (int unsigned i = 0; i < NUM_CH; i++)
            if (seg_q[i])
               upd_d[i*CH_WIDTH +: CH_WIDTH] = sr_q[i*CH_WIDTH +: CH_WIDTH];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sr_q  <= '0;
         upd_q <= '0;
         byp_q <= '0;
         seg_q <= '1;
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         sr_q  <= sr_d;
         upd_q <= upd_d;
         byp_q <= byp_d;
         seg_q <= seg_d;
         cnt_q <= cnt_d;
         err_q <= err_d;
      end
   end

   // Functional path: mode selects the update register in the same cycle.
   always_comb begin
      for (int unsigned i = 0; i < NUM_CH; i++)
         pout_c[i*CH_WIDTH +: CH_WIDTH] = bus.mode[i] ? upd_q[i*CH_WIDTH +: CH_WIDTH]
                                                      : bus.parallel_in[i*CH_WIDTH +: CH_WIDTH];
   end

   assign bus.parallel_out = pout_c;
   assign bus.tdo          = s_out[NUM_CH-1];
   assign bus.bit_count    = cnt_q;
   assign bus.proto_err    = err_q;
endmodule

// File: tb/tb_bsr_bank.sv
// Directed bench for bsr_bank with a queue-based chain model checked every cycle.
module tb_bsr_bank;
   localparam int NUM_CH   = 3;
   localparam int CH_WIDTH = 8;
   localparam int CNT_W    = 16;
   localparam int TOT_W    = NUM_CH * CH_WIDTH;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic clk   = 1'b0;
   logic reset = 1'b1;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   cmp_on = 1'b0;

   bsr_bank_if #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .CNT_W(CNT_W)) bus ();

   bsr_bank #(.NUM_CH(NUM_CH), .CH_WIDTH(CH_WIDTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Model: channel arrays plus a flat bit queue for the scan path (front = tdo end).
   logic [CH_WIDTH-1:0] m_sr  [NUM_CH];
   logic [CH_WIDTH-1:0] m_upd [NUM_CH];
   logic [NUM_CH-1:0]   m_byp, m_seg;
   int                  m_cnt;
   bit                  m_err;
   bit                  m_q[$];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void m_reset();
      for (int i = 0; i < NUM_CH; i++) begin
         m_sr[i]  = '0;
         m_upd[i] = '0;
      end
      m_byp = '0;
      m_seg = '1;
      m_cnt = 0;
      m_err = 1'b0;
   endfunction

   function automatic void m_pack();
      m_q.delete();
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m_seg[i]) for (int b = 0; b < CH_WIDTH; b++) m_q.push_back(m_sr[i][b]);
         else m_q.push_back(m_byp[i]);
      end
   endfunction

   function automatic void m_unpack();
      int p = 0;
      for (int i = NUM_CH - 1; i >= 0; i--) begin
         if (m_seg[i]) begin
            for (int b = 0; b < CH_WIDTH; b++) begin
               m_sr[i][b] = m_q[p];
               p++;
            end
         end else begin
            m_byp[i] = m_q[p];
            p++;
         end
      end
   endfunction

   function automatic logic m_tdo();
      m_pack();
      return m_q[0];
   endfunction

   function automatic logic [TOT_W-1:0] m_pout();
      logic [TOT_W-1:0] v;
      for (int i = 0; i < NUM_CH; i++)
         v[i*CH_WIDTH +: CH_WIDTH] = bus.mode[i] ? m_upd[i] : bus.parallel_in[i*CH_WIDTH +: CH_WIDTH];
      return v;
   endfunction

   // Applies the strobe rules to the model as seen at a rising edge.
   task automatic m_step();
      int n;
      if (reset) begin
         m_reset();
         return;
      end
      n = int'(bus.capture_dr) + int'(bus.shift_dr) + int'(bus.update_dr);
      if (n > 1) m_err = 1'b1;
      if (bus.capture_dr) begin
         m_seg = bus.seg_en;
         m_byp = '0;
         m_cnt = 0;
         for (int i = 0; i < NUM_CH; i++)
            if (bus.seg_en[i]) m_sr[i] = bus.parallel_in[i*CH_WIDTH +: CH_WIDTH];
      end else if (bus.shift_dr) begin
         m_pack();
         void'(m_q.pop_front());
         m_q.push_back(bus.tdi);
         m_unpack();
         if (m_cnt < CNT_MAX) m_cnt++;
      end else if (bus.update_dr) begin
         for (int i = 0; i < NUM_CH; i++)
            if (m_seg[i]) m_upd[i] = m_sr[i];
      end
   endtask

   task automatic drive(input logic c, input logic s, input logic u, input logic t);
      bus.capture_dr = c;
      bus.shift_dr   = s;
      bus.update_dr  = u;
      bus.tdi        = t;
      @(posedge clk);
      m_step();
      #1;
      bus.capture_dr = 1'b0;
      bus.shift_dr   = 1'b0;
      bus.update_dr  = 1'b0;
      bus.tdi        = 1'b0;
   endtask

   // Every-cycle comparison of all outputs against the model.
   initial begin
      forever begin
         @(negedge clk);
         if (cmp_on) begin
            chk("cyc_tdo",          64'(bus.tdo),          64'(m_tdo()));
            chk("cyc_bit_count",    64'(bus.bit_count),    64'(m_cnt));
            chk("cyc_proto_err",    64'(bus.proto_err),    64'(m_err));
            chk("cyc_parallel_out", 64'(bus.parallel_out), 64'(m_pout()));
         end
      end
   end

   initial begin
      logic [23:0] got;
      logic [23:0] pat;
      logic [9:0]  got10;

      bus.capture_dr  = 1'b0;
      bus.shift_dr    = 1'b0;
      bus.update_dr   = 1'b0;
      bus.tdi         = 1'b0;
      bus.seg_en      = 3'b111;
      bus.mode        = 3'b000;
      bus.parallel_in = 24'hA53C0F;
      m_reset();
      @(posedge clk);
      #1;
      cmp_on = 1'b1;

      // Reset values
      chk("rst_tdo",       64'(bus.tdo),          64'(0));
      chk("rst_bit_count", 64'(bus.bit_count),    64'(0));
      chk("rst_proto_err", 64'(bus.proto_err),    64'(0));
      chk("rst_pout_m0",   64'(bus.parallel_out), 64'(24'hA53C0F));
      bus.mode = 3'b111;
      #1;
      chk("rst_pout_m7",   64'(bus.parallel_out), 64'(0));
      bus.mode = 3'b000;
      @(negedge clk);
      reset = 1'b0;

      // Full-chain capture and shift-out
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 24; k++) begin
         got[k] = bus.tdo;
         drive(1'b0, 1'b1, 1'b0, 1'b0);
      end
      chk("c2_stream", 64'(got),           64'(24'h0F3CA5));
      chk("c2_count",  64'(bus.bit_count), 64'(24));

      // Shift in a pattern, update, per-channel mode
      pat = 24'h112233;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 24; k++) drive(1'b0, 1'b1, 1'b0, pat[k]);
      chk("c3_count", 64'(bus.bit_count), 64'(24));
      bus.mode = 3'b101;
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk("c3_pout",  64'(bus.parallel_out), 64'(24'h333C11));

      // Single enabled segment: 10-bit chain
      bus.seg_en      = 3'b010;
      bus.parallel_in = 24'hA5C30F;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      bus.seg_en      = 3'b101;
      for (int k = 0; k < 10; k++) begin
         got10[k] = bus.tdo;
         drive(1'b0, 1'b1, 1'b0, 1'b1);
      end
      chk("c4_stream", 64'(got10),         64'(10'h186));
      chk("c4_count",  64'(bus.bit_count), 64'(10));
      bus.mode = 3'b111;
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      chk("c4_pout",   64'(bus.parallel_out), 64'(24'h33FF11));

      // Strobe collisions
      bus.seg_en      = 3'b111;
      bus.parallel_in = 24'hA53C0F;
      drive(1'b1, 1'b1, 1'b0, 1'b1);
      chk("c5_err",    64'(bus.proto_err), 64'(1));
      chk("c5_count",  64'(bus.bit_count), 64'(0));
      chk("c5_tdo",    64'(bus.tdo),       64'(1));
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) drive(1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 1'b1, 1'b0);
      chk("c5_sticky", 64'(bus.proto_err), 64'(1));
      chk("c5_count2", 64'(bus.bit_count), 64'(4));

      // Async reset mid-scan, then the full-chain scan again
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) drive(1'b0, 1'b1, 1'b0, 1'b1);
      reset = 1'b1;
      m_reset();
      #1;
      chk("c6_count", 64'(bus.bit_count),    64'(0));
      chk("c6_tdo",   64'(bus.tdo),          64'(0));
      chk("c6_err",   64'(bus.proto_err),    64'(0));
      chk("c6_pout",  64'(bus.parallel_out), 64'(0));
      @(negedge clk);
      #1;
      reset = 1'b0;
      drive(1'b1, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 24; k++) begin
         got[k] = bus.tdo;
         drive(1'b0, 1'b1, 1'b0, 1'b0);
      end
      chk("c6_stream", 64'(got),           64'(24'h0F3CA5));
      chk("c6_count2", 64'(bus.bit_count), 64'(24));
      @(negedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
